// File: rtl/pwm_fader.sv
// Bus-programmable duty ramp feeding a PWM write port; optional completion irq via PWM_FADER_IRQ_EN.
// Latency: TARGET write at N -> busy at N+1, first tick at N+1+DIV, PWM strobe at N+2+DIV.
// Backpressure: none; the PWM port always accepts a one-cycle cs/wren strobe.
module pwm_fader #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             cs,
  input  logic             wren,
  input  logic [1:0]       addr,
  input  logic [31:0]      di,
  output logic [31:0]      dout,
  output logic             pwm_cs,
  output logic             pwm_wren,
  output logic [WIDTH-1:0] pwm_di
`ifdef PWM_FADER_IRQ_EN
  ,
  output logic             irq
`endif
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     current, current_nxt;
  logic [WIDTH-1:0]     target, target_nxt;
  logic [WIDTH-1:0]     step;
  logic [DIV_WIDTH-1:0] div;
  logic [DIV_WIDTH-1:0] presc, presc_nxt;
  logic                 strobe, strobe_nxt;
  logic                 irq_flag;
  logic                 busy;
  logic                 unused_di;

  logic                 wr, tgt_wr, div_wr, step_wr;
  logic [WIDTH-1:0]     new_tgt;
  logic                 tick;
  logic                 up;
  logic [WIDTH-1:0]     step_eff, diff, stepped;
  logic [31:0]          rd;

  assign wr      = cs & wren;
  assign tgt_wr  = wr && (addr == 2'd0);
  assign div_wr  = wr && (addr == 2'd1);
  assign step_wr = wr && (addr == 2'd2);
  assign new_tgt = di[WIDTH-1:0];
  assign busy    = (state == ST_RUN);
  assign tick    = (presc == div);

  // Distance is taken in the ordered direction so the clamp test never overflows.
  assign step_eff = (step == '0) ? WIDTH'(1) : step;
  assign up       = (target > current);
  assign diff     = up ? (target - current) : (current - target);
  assign stepped  = (diff <= step_eff) ? target
                  : (up ? (current + step_eff) : (current - step_eff));

  always_comb begin
    state_nxt   = state;
    current_nxt = current;
    target_nxt  = tgt_wr ? new_tgt : target;
    presc_nxt   = presc;
    strobe_nxt  = 1'b0;
    case (state)
      ST_INIT: begin
        strobe_nxt = 1'b1;
        presc_nxt  = '0;
        state_nxt  = (tgt_wr && (new_tgt != current)) ? ST_RUN : ST_IDLE;
      end
      ST_IDLE: begin
        if (tgt_wr && (new_tgt != current)) begin
          state_nxt = ST_RUN;
          presc_nxt = '0;
        end
      end
      ST_RUN: begin
        if (tick) begin
          // Step toward the old target; completion is judged against the target in force next cycle.
          presc_nxt   = '0;
          current_nxt = stepped;
          strobe_nxt  = 1'b1;
          if (stepped == target_nxt) state_nxt = ST_IDLE;
        end else begin
          presc_nxt = presc + DIV_WIDTH'(1);
          if (target_nxt == current) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state   <= ST_INIT;
      current <= '0;
      target  <= '0;
      div     <= '0;
      step    <= WIDTH'(1);
      presc   <= '0;
      strobe  <= 1'b0;
      pwm_di  <= '0;
    end else begin
      state   <= state_nxt;
      current <= current_nxt;
      target  <= target_nxt;
      presc   <= presc_nxt;
      strobe  <= strobe_nxt;
      if (strobe_nxt) pwm_di <= current_nxt;
      if (div_wr)     div    <= di[DIV_WIDTH-1:0];
      if (step_wr)    step   <= di[WIDTH-1:0];
    end
  end

  assign pwm_cs   = strobe;
  assign pwm_wren = strobe;

`ifdef PWM_FADER_IRQ_EN
  logic stat_clr;
  logic irq_set;
  assign stat_clr = wr && (addr == 2'd3) && di[16];
  assign irq_set  = (state == ST_RUN) && (state_nxt == ST_IDLE);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      irq_flag <= 1'b0;
    end else begin
      irq_flag <= irq_set | (irq_flag & ~stat_clr);
    end
  end

  assign irq = irq_flag;
`else
  assign irq_flag = 1'b0;
`endif

  always_comb begin
    rd = '0;
    case (addr)
      2'd0: rd[WIDTH-1:0]     = target;
      2'd1: rd[DIV_WIDTH-1:0] = div;
      2'd2: rd[WIDTH-1:0]     = step;
      default: begin
        rd[WIDTH-1:0] = current;
        rd[15]        = busy;
        rd[16]        = irq_flag;
      end
    endcase
  end

  assign dout      = cs ? rd : '0;
  assign unused_di = ^di;

endmodule

// File: tb/tb_pwm_fader.sv
// Directed bench for pwm_fader: init write, ramps, clamping, redirects, reset, optional irq.
module tb_pwm_fader;

  localparam int WIDTH     = 8;
  localparam int DIV_WIDTH = 16;
`ifdef PWM_FADER_IRQ_EN
  localparam logic [31:0] IRQ_BIT = 32'h0001_0000;
`else
  localparam logic [31:0] IRQ_BIT = 32'h0000_0000;
`endif

  logic             sys_clk = 1'b0;
  logic             sys_rst_n;
  logic             cs;
  logic             wren;
  logic [1:0]       addr;
  logic [31:0]      di;
  logic [31:0]      dout;
  logic             pwm_cs;
  logic             pwm_wren;
  logic [WIDTH-1:0] pwm_di;
`ifdef PWM_FADER_IRQ_EN
  logic             irq;
`endif

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  int               sc[$];
  logic [WIDTH-1:0] sv[$];
  logic             scs[$];

  pwm_fader #(.WIDTH(WIDTH), .DIV_WIDTH(DIV_WIDTH)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .cs       (cs),
    .wren     (wren),
    .addr     (addr),
    .di       (di),
    .dout     (dout),
    .pwm_cs   (pwm_cs),
    .pwm_wren (pwm_wren),
    .pwm_di   (pwm_di)
`ifdef PWM_FADER_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc = cyc + 1;

  always @(negedge sys_clk) begin
    if (pwm_wren === 1'b1) begin
      sc.push_back(cyc);
      sv.push_back(pwm_di);
      scs.push_back(pwm_cs);
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic clear_log();
    sc.delete();
    sv.delete();
    scs.delete();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; wren = 1'b1; addr = a; di = d;
    cycles(1);
    cs = 1'b0; wren = 1'b0; di = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    cs = 1'b1; wren = 1'b0; addr = a;
    #1;
    d = dout;
    cs = 1'b0; addr = 2'd0;
  endtask

  task automatic test_reset();
    logic [31:0] rv;
    sys_rst_n = 1'b0; cs = 1'b0; wren = 1'b0; addr = 2'd0; di = '0;
    cycles(3);
    checks++; if (pwm_wren !== 1'b0) begin fails++; $display("FAIL reset_pwm_wren: got %b want 0", pwm_wren); end
    checks++; if (pwm_cs !== 1'b0) begin fails++; $display("FAIL reset_pwm_cs: got %b want 0", pwm_cs); end
    checks++; if (pwm_di !== 8'h00) begin fails++; $display("FAIL reset_pwm_di: got %h want 00", pwm_di); end
    checks++; if (dout !== 32'h0) begin fails++; $display("FAIL dout_no_cs: got %h want 0", dout); end
    bus_read(2'd2, rv);
    checks++; if (rv !== 32'h1) begin fails++; $display("FAIL reset_step: got %h want 1", rv); end
    bus_read(2'd1, rv);
    checks++; if (rv !== 32'h0) begin fails++; $display("FAIL reset_div: got %h want 0", rv); end
    clear_log();
    sys_rst_n = 1'b1;
    cycles(6);
    checks++; if (sc.size() != 1) begin fails++; $display("FAIL init_strobe_count: got %0d want 1", sc.size()); end
    else begin
      checks++; if (sv[0] !== 8'h00) begin fails++; $display("FAIL init_strobe_val: got %h want 00", sv[0]); end
      checks++; if (scs[0] !== 1'b1) begin fails++; $display("FAIL init_strobe_cs: got %b want 1", scs[0]); end
    end
    bus_read(2'd3, rv);
    checks++; if (rv !== 32'h0) begin fails++; $display("FAIL init_status: got %h want 0", rv); end
  endtask

  task automatic test_ramp();
    logic [31:0] rv;
    int n;
    bus_write(2'd1, 32'd3);
    bus_write(2'd2, 32'd1);
    clear_log();
    n = cyc;
    bus_write(2'd0, 32'd4);
    bus_read(2'd3, rv);
    checks++; if (rv !== 32'h0000_8000) begin fails++; $display("FAIL ramp_busy_rise: got %h want 00008000", rv); end
    cycles(15);
    bus_read(2'd3, rv);
    checks++; if (rv !== 32'h0000_8003) begin fails++; $display("FAIL ramp_last_tick: got %h want 00008003", rv); end
    cycles(1);
    bus_read(2'd3, rv);
    checks++; if (rv !== (32'h4 | IRQ_BIT)) begin fails++; $display("FAIL ramp_done_status: got %h want %h", rv, 32'h4 | IRQ_BIT); end
    cycles(4);
    checks++; if (sc.size() != 4) begin fails++; $display("FAIL ramp_count: got %0d want 4", sc.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (sc[i] != n + 5 + 4 * i) begin fails++; $display("FAIL ramp_cycle[%0d]: got %0d want %0d", i, sc[i] - n, 5 + 4 * i); end
        checks++; if (sv[i] !== 8'(i + 1)) begin fails++; $display("FAIL ramp_val[%0d]: got %h want %h", i, sv[i], 8'(i + 1)); end
      end
    end
    checks++; if (pwm_di !== 8'h04) begin fails++; $display("FAIL ramp_di_hold: got %h want 04", pwm_di); end
  endtask

  task automatic test_clamp();
    logic [31:0] rv;
    int n;
    bus_write(2'd1, 32'd0);
    bus_write(2'd2, 32'd255);
    bus_write(2'd0, 32'd250);
    cycles(3);
    clear_log();
    bus_write(2'd2, 32'd10);
    bus_write(2'd0, 32'd255);
    cycles(3);
    checks++; if (sc.size() != 1) begin fails++; $display("FAIL clamp_up_count: got %0d want 1", sc.size()); end
    else begin
      checks++; if (sv[0] !== 8'hFF) begin fails++; $display("FAIL clamp_up_val: got %h want ff", sv[0]); end
    end
    bus_read(2'd3, rv);
    checks++; if (rv[15:0] !== 16'h00FF) begin fails++; $display("FAIL clamp_up_status: got %h want 00ff", rv[15:0]); end
    bus_write(2'd0, 32'd250);
    cycles(3);
    bus_read(2'd3, rv);
    checks++; if (rv[15:0] !== 16'h00FA) begin fails++; $display("FAIL clamp_down_status: got %h want 00fa", rv[15:0]); end
    clear_log();
    bus_write(2'd2, 32'd100);
    n = cyc;
    bus_write(2'd0, 32'd0);
    cycles(5);
    checks++; if (sc.size() != 3) begin fails++; $display("FAIL floor_count: got %0d want 3", sc.size()); end
    else begin
      checks++; if (sv[0] !== 8'd150) begin fails++; $display("FAIL floor_val0: got %0d want 150", sv[0]); end
      checks++; if (sv[1] !== 8'd50) begin fails++; $display("FAIL floor_val1: got %0d want 50", sv[1]); end
      checks++; if (sv[2] !== 8'd0) begin fails++; $display("FAIL floor_val2: got %0d want 0", sv[2]); end
      checks++; if (sc[0] != n + 2) begin fails++; $display("FAIL floor_first_cycle: got %0d want 2", sc[0] - n); end
    end
  endtask

  task automatic test_reverse();
    logic [31:0] rv;
    int n;
    bus_write(2'd1, 32'd9);
    bus_write(2'd2, 32'd4);
    clear_log();
    n = cyc;
    bus_write(2'd0, 32'h80);
    cycles(64);
    bus_write(2'd0, 32'h10);
    cycles(20);
    checks++; if (sc.size() != 8) begin fails++; $display("FAIL rev_count: got %0d want 8", sc.size()); end
    else begin
      checks++; if (sv[5] !== 8'd24) begin fails++; $display("FAIL rev_peak: got %0d want 24", sv[5]); end
      checks++; if (sv[6] !== 8'd20) begin fails++; $display("FAIL rev_val6: got %0d want 20", sv[6]); end
      checks++; if (sc[6] != n + 71) begin fails++; $display("FAIL rev_phase6: got %0d want 71", sc[6] - n); end
      checks++; if (sv[7] !== 8'd16) begin fails++; $display("FAIL rev_val7: got %0d want 16", sv[7]); end
      checks++; if (sc[7] != n + 81) begin fails++; $display("FAIL rev_phase7: got %0d want 81", sc[7] - n); end
    end
    bus_read(2'd3, rv);
    checks++; if (rv[15:0] !== 16'h0010) begin fails++; $display("FAIL rev_status: got %h want 0010", rv[15:0]); end
  endtask

  task automatic test_equal_and_step0();
    logic [31:0] rv;
    clear_log();
    bus_write(2'd0, 32'h10);
    bus_read(2'd3, rv);
    checks++; if (rv[15:0] !== 16'h0010) begin fails++; $display("FAIL eq_busy: got %h want 0010", rv[15:0]); end
    cycles(5);
    checks++; if (sc.size() != 0) begin fails++; $display("FAIL eq_no_strobe: got %0d want 0", sc.size()); end
    bus_write(2'd1, 32'd0);
    bus_write(2'd2, 32'd0);
    bus_read(2'd2, rv);
    checks++; if (rv !== 32'h0) begin fails++; $display("FAIL step0_readback: got %h want 0", rv); end
    clear_log();
    bus_write(2'd0, 32'd18);
    cycles(5);
    checks++; if (sc.size() != 2) begin fails++; $display("FAIL step0_count: got %0d want 2", sc.size()); end
    else begin
      checks++; if (sv[0] !== 8'd17) begin fails++; $display("FAIL step0_val0: got %0d want 17", sv[0]); end
      checks++; if (sv[1] !== 8'd18) begin fails++; $display("FAIL step0_val1: got %0d want 18", sv[1]); end
    end
  endtask

  task automatic test_redirect_equal();
    logic [31:0] rv;
    int n;
    bus_write(2'd1, 32'd9);
    bus_write(2'd2, 32'd1);
    clear_log();
    n = cyc;
    bus_write(2'd0, 32'h20);
    cycles(14);
    bus_write(2'd0, 32'd19);
    bus_read(2'd3, rv);
    checks++; if (rv[15:0] !== 16'h0013) begin fails++; $display("FAIL redir_eq_status: got %h want 0013", rv[15:0]); end
    cycles(15);
    checks++; if (sc.size() != 1) begin fails++; $display("FAIL redir_eq_count: got %0d want 1", sc.size()); end
    else begin
      checks++; if (sv[0] !== 8'd19) begin fails++; $display("FAIL redir_eq_val: got %0d want 19", sv[0]); end
      checks++; if (sc[0] != n + 11) begin fails++; $display("FAIL redir_eq_cycle: got %0d want 11", sc[0] - n); end
    end
  endtask

  task automatic test_midfade_reset();
    logic [31:0] rv;
    bus_write(2'd0, 32'h40);
    cycles(24);
    sys_rst_n = 1'b0;
    cycles(1);
    checks++; if (pwm_wren !== 1'b0) begin fails++; $display("FAIL mid_rst_wren: got %b want 0", pwm_wren); end
    checks++; if (pwm_di !== 8'h00) begin fails++; $display("FAIL mid_rst_di: got %h want 00", pwm_di); end
    bus_read(2'd3, rv);
    checks++; if (rv !== 32'h0) begin fails++; $display("FAIL mid_rst_status: got %h want 0", rv); end
    cycles(1);
    sys_rst_n = 1'b1;
    clear_log();
    cycles(5);
    checks++; if (sc.size() != 1) begin fails++; $display("FAIL mid_rst_init_count: got %0d want 1", sc.size()); end
    else begin
      checks++; if (sv[0] !== 8'h00) begin fails++; $display("FAIL mid_rst_init_val: got %h want 00", sv[0]); end
    end
    bus_read(2'd0, rv);
    checks++; if (rv !== 32'h0) begin fails++; $display("FAIL mid_rst_target: got %h want 0", rv); end
    bus_read(2'd1, rv);
    checks++; if (rv !== 32'h0) begin fails++; $display("FAIL mid_rst_div: got %h want 0", rv); end
    bus_read(2'd2, rv);
    checks++; if (rv !== 32'h1) begin fails++; $display("FAIL mid_rst_step: got %h want 1", rv); end
  endtask

`ifdef PWM_FADER_IRQ_EN
  task automatic test_irq();
    logic [31:0] rv;
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_reset: got %b want 0", irq); end
    bus_write(2'd1, 32'd0);
    bus_write(2'd2, 32'd1);
    bus_write(2'd0, 32'd1);
    cycles(2);
    checks++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_set: got %b want 1", irq); end
    bus_write(2'd3, 32'h0);
    checks++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_sticky: got %b want 1", irq); end
    bus_write(2'd3, 32'h0001_0000);
    checks++; if (irq !== 1'b0) begin fails++; $display("FAIL irq_clear: got %b want 0", irq); end
    bus_write(2'd0, 32'd2);
    bus_write(2'd3, 32'h0001_0000);
    checks++; if (irq !== 1'b1) begin fails++; $display("FAIL irq_set_wins: got %b want 1", irq); end
    bus_read(2'd3, rv);
    checks++; if (rv !== 32'h0001_0002) begin fails++; $display("FAIL irq_status: got %h want 00010002", rv); end
  endtask
`endif

  initial begin
    test_reset();
    test_ramp();
    test_clamp();
    test_reverse();
    test_equal_and_step0();
    test_redirect_equal();
    test_midfade_reset();
`ifdef PWM_FADER_IRQ_EN
    test_irq();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
